pmips_fetch: RTL and testbench

PMIPS_FETCH -- requirements
Module: pmips_fetch

---
 rtl/pmips_fetch.sv | 109 ++++++++++
 tb/tb_pmips_fetch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pmips_fetch.sv
// Instruction fetch stage: PC register, IF/ID latch and FILL/RUN/REDIRECT sequencing, plus stall and flush counters.
// One-edge latency from IMemData to IFID; PCStall holds PC and IF/ID, BranchTaken overrides it and flushes.
module pmips_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCStall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    input  logic [15:0] IMemData,
    output logic [15:0] IMemAddr,
    output logic [15:0] IFID,
    output logic [15:0] IFIDPC,
    output logic        IFIDValid,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    typedef enum logic [1:0] {
        FILL     = 2'b00,
        RUN      = 2'b01,
        REDIRECT = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ifid_q, ifid_d;
    logic [15:0] ifid_pc_q, ifid_pc_d;
    logic        ifid_vld_q, ifid_vld_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic [15:0] pc_plus2;
    logic [15:0] stall_cnt_inc;
    logic [15:0] flush_cnt_inc;

    assign pc_plus2      = pc_q + 16'd2;
    assign stall_cnt_inc = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;
    assign flush_cnt_inc = (flush_cnt_q == 16'hFFFF) ? flush_cnt_q : flush_cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ifid_d      = ifid_q;
        ifid_pc_d   = ifid_pc_q;
        ifid_vld_d  = ifid_vld_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            FILL: begin
                // Control inputs are ignored here; the first real fetch happens in RUN.
                pc_d       = 16'h0000;
                ifid_d     = 16'h0000;
                ifid_pc_d  = 16'h0000;
                ifid_vld_d = 1'b0;
                state_d    = RUN;
            end
            RUN, REDIRECT: begin
                if (BranchTaken) begin
                    pc_d        = BranchTarget & 16'hFFFE;
                    ifid_d      = 16'h0000;
                    ifid_pc_d   = 16'h0000;
                    ifid_vld_d  = 1'b0;
                    flush_cnt_d = flush_cnt_inc;
                    state_d     = REDIRECT;
                end else if (PCStall) begin
                    stall_cnt_d = stall_cnt_inc;
                end else begin
                    pc_d       = pc_plus2;
                    ifid_d     = IMemData;
                    ifid_pc_d  = pc_plus2;
                    ifid_vld_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FILL;
            pc_q        <= 16'h0000;
            ifid_q      <= 16'h0000;
            ifid_pc_q   <= 16'h0000;
            ifid_vld_q  <= 1'b0;
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ifid_q      <= ifid_d;
            ifid_pc_q   <= ifid_pc_d;
            ifid_vld_q  <= ifid_vld_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign IMemAddr   = pc_q;
    assign IFID       = ifid_q;
    assign IFIDPC     = ifid_pc_q;
    assign IFIDValid  = ifid_vld_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pmips_fetch.sv
// Directed bench for pmips_fetch: reset, straight-line fetch, stalls, branches, wrap, saturation.
module tb_pmips_fetch;

    logic        clock;
    logic        reset;
    logic        PCStall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [15:0] IMemData;
    logic [15:0] IMemAddr;
    logic [15:0] IFID;
    logic [15:0] IFIDPC;
    logic        IFIDValid;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    int vectors = 0;
    int miscompares = 0;

    pmips_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .PCStall     (PCStall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .IMemData    (IMemData),
        .IMemAddr    (IMemAddr),
        .IFID        (IFID),
        .IFIDPC      (IFIDPC),
        .IFIDValid   (IFIDValid),
        .StallCount  (StallCount),
        .FlushCount  (FlushCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory image: 0x1000+address, except a marker word at 0x000E.
    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        logic [15:0] w;
        w = 16'h1000 + addr;
        if (addr == 16'h000E) w = 16'h2A81;
        return w;
    endfunction

    always_comb IMemData = mem_word(IMemAddr);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        PCStall = 1'b0;
        BranchTaken = 1'b0;
        BranchTarget = 16'h0000;
        step();
        step();
        check("rst_ifid", IFID, 16'h0000);
        check("rst_ifidpc", IFIDPC, 16'h0000);
        check("rst_vld", {15'd0, IFIDValid}, 16'd0);
        check("rst_addr", IMemAddr, 16'h0000);
        check("rst_stall", StallCount, 16'h0000);
        check("rst_flush", FlushCount, 16'h0000);

        // Straight-line fetch: edge 1 leaves FILL, edge 2 lands address 0.
        reset = 1'b0;
        step();
        check("fill_vld", {15'd0, IFIDValid}, 16'd0);
        check("fill_addr", IMemAddr, 16'h0000);
        step();
        check("first_ifid", IFID, 16'h1000);
        check("first_vld", {15'd0, IFIDValid}, 16'd1);
        check("first_ifidpc", IFIDPC, 16'h0002);
        step();
        step();
        check("e4_ifid", IFID, 16'h1004);
        check("e4_ifidpc", IFIDPC, 16'h0006);
        check("e4_addr", IMemAddr, 16'h0006);

        repeat (5) step();
        check("pre_stall_ifid", IFID, 16'h2A81);
        check("pre_stall_addr", IMemAddr, 16'h0010);

        // Three-cycle stall holds everything.
        PCStall = 1'b1;
        repeat (3) step();
        check("stall_ifid", IFID, 16'h2A81);
        check("stall_addr", IMemAddr, 16'h0010);
        check("stall_vld", {15'd0, IFIDValid}, 16'd1);
        check("stall_ifidpc", IFIDPC, 16'h0010);
        check("stall_cnt", StallCount, 16'd3);
        PCStall = 1'b0;
        step();
        check("resume_ifid", IFID, 16'h1010);
        check("resume_addr", IMemAddr, 16'h0012);

        // Branch wins over stall; target bit 0 dropped.
        BranchTaken = 1'b1;
        PCStall = 1'b1;
        BranchTarget = 16'h0041;
        step();
        check("br_addr", IMemAddr, 16'h0040);
        check("br_ifid", IFID, 16'h0000);
        check("br_vld", {15'd0, IFIDValid}, 16'd0);
        check("br_ifidpc", IFIDPC, 16'h0000);
        check("br_flush", FlushCount, 16'd1);
        check("br_stall", StallCount, 16'd3);
        BranchTaken = 1'b0;
        PCStall = 1'b0;
        step();
        check("br_fetch_ifid", IFID, 16'h1040);
        check("br_fetch_vld", {15'd0, IFIDValid}, 16'd1);
        check("br_fetch_addr", IMemAddr, 16'h0042);
        check("br_fetch_ifidpc", IFIDPC, 16'h0042);

        // Stall while in REDIRECT keeps the bubble.
        BranchTaken = 1'b1;
        BranchTarget = 16'h0080;
        step();
        BranchTaken = 1'b0;
        PCStall = 1'b1;
        step();
        check("rdst_addr", IMemAddr, 16'h0080);
        check("rdst_vld", {15'd0, IFIDValid}, 16'd0);
        check("rdst_ifid", IFID, 16'h0000);
        check("rdst_stall", StallCount, 16'd4);
        check("rdst_flush", FlushCount, 16'd2);
        PCStall = 1'b0;
        step();
        check("rdst_fetch_ifid", IFID, 16'h1080);
        check("rdst_fetch_addr", IMemAddr, 16'h0082);

        // PC wrap at 0xFFFE.
        BranchTaken = 1'b1;
        BranchTarget = 16'hFFFE;
        step();
        BranchTaken = 1'b0;
        step();
        check("wrap_addr", IMemAddr, 16'h0000);
        check("wrap_ifidpc", IFIDPC, 16'h0000);
        check("wrap_ifid", IFID, 16'h0FFE);

        // Back-to-back branches, second taken from REDIRECT.
        BranchTaken = 1'b1;
        BranchTarget = 16'h0020;
        step();
        BranchTarget = 16'h0031;
        step();
        check("b2b_addr", IMemAddr, 16'h0030);
        check("b2b_flush", FlushCount, 16'd5);
        check("b2b_vld", {15'd0, IFIDValid}, 16'd0);

        // Reset on the edge after a flush, with controls asserted throughout.
        BranchTarget = 16'h0050;
        step();
        reset = 1'b1;
        PCStall = 1'b1;
        step();
        check("rr_addr", IMemAddr, 16'h0000);
        check("rr_flush", FlushCount, 16'd0);
        check("rr_stall", StallCount, 16'd0);
        check("rr_ifid", IFID, 16'h0000);
        reset = 1'b0;
        step();
        check("rr_fill_vld", {15'd0, IFIDValid}, 16'd0);
        check("rr_fill_addr", IMemAddr, 16'h0000);
        check("rr_fill_flush", FlushCount, 16'd0);
        check("rr_fill_stall", StallCount, 16'd0);
        BranchTaken = 1'b0;
        PCStall = 1'b0;
        step();
        check("rr_fetch_ifid", IFID, 16'h1000);
        check("rr_fetch_addr", IMemAddr, 16'h0002);

        // Saturating stall counter.
        PCStall = 1'b1;
        repeat (65535) @(posedge clock);
        #1;
        check("sat_reach", StallCount, 16'hFFFF);
        step();
        step();
        check("sat_hold", StallCount, 16'hFFFF);
        check("sat_addr", IMemAddr, 16'h0002);
        PCStall = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
